// File: rtl/modality_fuser.sv
// modality_fuser: fold-wise 3-input majority fusion of GSR/ECG/EEG slices
// into one hypervector. Define FUSER_ERR_CHECK_EN for the sticky error flag.
module modality_fuser #(
    parameter int NUM_FOLDS       = 1,
    parameter int NUM_FOLDS_WIDTH = 1,
    parameter int FOLD_WIDTH      = 2000,
    localparam int HV_WIDTH       = NUM_FOLDS * FOLD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hvin_valid,
    output logic                       hvin_ready,
    input  logic [FOLD_WIDTH-1:0]      hvin,
    input  logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
    input  logic                       enc_done,
    output logic                       fused_valid,
    input  logic                       fused_ready,
    output logic [HV_WIDTH-1:0]        fused_hv,
    output logic                       error
);

    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD =
        NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    typedef enum logic [1:0] {
        WAIT_GSR,
        WAIT_ECG,
        WAIT_EEG,
        OUT_VALID
    } state_t;

    state_t                     state;
    logic [NUM_FOLDS_WIDTH-1:0] fold_cnt;
    logic [FOLD_WIDTH-1:0]      gsr_reg;
    logic [FOLD_WIDTH-1:0]      ecg_reg;
    logic [FOLD_WIDTH-1:0]      maj;
    logic                       in_fire;
    logic                       out_fire;

    // Ready depends only on state, never on fused_ready.
    assign hvin_ready = (state != OUT_VALID);
    assign in_fire    = hvin_valid && hvin_ready;
    assign out_fire   = fused_valid && fused_ready;
    assign maj        = (gsr_reg & ecg_reg) | (gsr_reg & hvin) |
                        (ecg_reg & hvin);

    // Slice collection FSM; enc_done outside OUT_VALID resyncs and drops the slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_GSR;
            fold_cnt    <= '0;
            gsr_reg     <= '0;
            ecg_reg     <= '0;
            fused_hv    <= '0;
            fused_valid <= 1'b0;
        end else if (enc_done && state != OUT_VALID) begin
            state    <= WAIT_GSR;
            fold_cnt <= '0;
        end else begin
            unique case (state)
                WAIT_GSR: begin
                    if (in_fire) begin
                        gsr_reg <= hvin;
                        state   <= WAIT_ECG;
                    end
                end
                WAIT_ECG: begin
                    if (in_fire) begin
                        ecg_reg <= hvin;
                        state   <= WAIT_EEG;
                    end
                end
                WAIT_EEG: begin
                    if (in_fire) begin
                        for (int f = 0; f < NUM_FOLDS; f++) begin
                            if (fold_cnt == NUM_FOLDS_WIDTH'(f))
                                fused_hv[f*FOLD_WIDTH +: FOLD_WIDTH] <= maj;
                        end
                        if (fold_cnt == LAST_FOLD) begin
                            fold_cnt    <= '0;
                            state       <= OUT_VALID;
                            fused_valid <= 1'b1;
                        end else begin
                            fold_cnt <= fold_cnt + NUM_FOLDS_WIDTH'(1);
                            state    <= WAIT_GSR;
                        end
                    end
                end
                OUT_VALID: begin
                    if (out_fire) begin
                        state       <= WAIT_GSR;
                        fused_valid <= 1'b0;
                    end
                end
                default: state <= WAIT_GSR;
            endcase
        end
    end

`ifdef FUSER_ERR_CHECK_EN
    logic err_lost;
    logic err_early;
    logic err_fold;

    assign err_lost  = hvin_valid && !hvin_ready;
    assign err_early = enc_done && state != OUT_VALID;
    assign err_fold  = in_fire && (fold_idx != fold_cnt);

    // Sticky protocol error: lost slice, partial sample or fold mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            error <= 1'b0;
        else if (err_lost || err_early || err_fold)
            error <= 1'b1;
    end
`else
    logic unused_fold_idx;

    assign unused_fold_idx = ^fold_idx;
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_modality_fuser.sv
// tb_modality_fuser: directed vectors, scoreboard of expected fused HVs
// popped by a monitor on every output handshake.
module tb_modality_fuser;

    localparam int NF = 2;
    localparam int NW = 1;
    localparam int FW = 4;
    localparam int HW = NF * FW;

`ifdef FUSER_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          hvin_valid;
    logic          hvin_ready;
    logic [FW-1:0] hvin;
    logic [NW-1:0] fold_idx;
    logic          enc_done;
    logic          fused_valid;
    logic          fused_ready;
    logic [HW-1:0] fused_hv;
    logic          error;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [HW-1:0] exp_q[$];

    modality_fuser #(
        .NUM_FOLDS      (NF),
        .NUM_FOLDS_WIDTH(NW),
        .FOLD_WIDTH     (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hvin_valid (hvin_valid),
        .hvin_ready (hvin_ready),
        .hvin       (hvin),
        .fold_idx   (fold_idx),
        .enc_done   (enc_done),
        .fused_valid(fused_valid),
        .fused_ready(fused_ready),
        .fused_hv   (fused_hv),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && fused_valid) begin
            valid_cycles++;
            if (fused_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got %0h want none", fused_hv);
                end else begin
                    chk("sb_fused_hv", 32'(fused_hv), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FW-1:0] d, input logic [NW-1:0] idx);
        hvin_valid = 1'b1;
        hvin       = d;
        fold_idx   = idx;
        tick();
        hvin_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_base(input logic [NW-1:0] idx0,
                             input logic [NW-1:0] idx1);
        send(4'b1100, idx0);
        send(4'b1010, idx0);
        send(4'b0110, idx0);
        send(4'b0001, idx1);
        send(4'b0011, idx1);
        send(4'b0101, idx1);
    endtask

    initial begin
        rst         = 1'b1;
        hvin_valid  = 1'b0;
        hvin        = '0;
        fold_idx    = '0;
        enc_done    = 1'b0;
        fused_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(fused_valid), 0);
        chk("rst_hv", 32'(fused_hv), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_hvin_ready", 32'(hvin_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // Basic fusion with fused_ready held high
        valid_cycles = 0;
        exp_q.push_back(8'h1E);
        send_base(0, 1);
        chk("basic_valid_rise", 32'(fused_valid), 1);
        chk("basic_hv", 32'(fused_hv), 32'h1E);
        tick();
        chk("basic_valid_fall", 32'(fused_valid), 0);
        tick();
        tick();
        chk("basic_pulse_len", 32'(valid_cycles), 1);
        chk("basic_error", 32'(error), 0);

        // Backpressure: 5 cycles held, released on the 6th
        exp_q.push_back(8'h1E);
        fused_ready = 1'b0;
        send_base(0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(fused_valid), 1);
            chk("bp_hv", 32'(fused_hv), 32'h1E);
            chk("bp_hvin_ready", 32'(hvin_ready), 0);
            tick();
        end
        fused_ready = 1'b1;
        chk("bp_valid_last", 32'(fused_valid), 1);
        chk("bp_hv_last", 32'(fused_hv), 32'h1E);
        tick();
        chk("bp_valid_fall", 32'(fused_valid), 0);
        chk("bp_hvin_ready_back", 32'(hvin_ready), 1);
        tick();

        // Overflow: slice while holding output is lost
        exp_q.push_back(8'h1E);
        fused_ready = 1'b0;
        send_base(0, 1);
        tick();
        send(4'b1111, 0);
        chk("ovf_hv_held", 32'(fused_hv), 32'h1E);
        chk("ovf_valid_held", 32'(fused_valid), 1);
        chk("ovf_error", 32'(error), 32'(ERR_EXP));
        fused_ready = 1'b1;
        tick();
        exp_q.push_back(8'hFA);
        send(4'b1111, 0);
        send(4'b0000, 0);
        send(4'b1010, 0);
        send(4'b1111, 1);
        send(4'b1111, 1);
        send(4'b0000, 1);
        chk("ovf_next_hv", 32'(fused_hv), 32'hFA);
        tick();
        tick();

        // Early done: partial sample discarded
        do_reset();
        send(4'b1111, 0);
        send(4'b1111, 0);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("early_error", 32'(error), 32'(ERR_EXP));
        chk("early_no_valid", 32'(fused_valid), 0);
        exp_q.push_back(8'hE0);
        send(4'b0000, 0);
        send(4'b0000, 0);
        send(4'b1111, 0);
        send(4'b1100, 1);
        send(4'b1010, 1);
        send(4'b0110, 1);
        chk("early_hv", 32'(fused_hv), 32'hE0);
        tick();
        tick();

        // Fold mismatch: placement follows internal count
        do_reset();
        chk("mis_pre_error", 32'(error), 0);
        exp_q.push_back(8'h1E);
        send_base(1, 1);
        chk("mis_hv", 32'(fused_hv), 32'h1E);
        chk("mis_error", 32'(error), 32'(ERR_EXP));
        tick();
        tick();

        // Async reset between edges while waiting for EEG
        send(4'b1111, 0);
        send(4'b1111, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(fused_valid), 0);
        chk("arst_hv", 32'(fused_hv), 0);
        chk("arst_error", 32'(error), 0);
        chk("arst_hvin_ready", 32'(hvin_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // Post-reset sample still fuses from a clean start
        exp_q.push_back(8'h1E);
        send_base(0, 1);
        chk("post_hv", 32'(fused_hv), 32'h1E);
        tick();
        tick();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
